// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - default raster timing, counter types and sync/blank bundle
package video_pkg;

    localparam int VGA_H_ACTIVE   = 1024;
    localparam int VGA_H_FP       = 24;
    localparam int VGA_H_SYNC     = 136;
    localparam int VGA_H_BP       = 160;
    localparam int VGA_V_ACTIVE   = 768;
    localparam int VGA_V_FP       = 3;
    localparam int VGA_V_SYNC     = 6;
    localparam int VGA_V_BP       = 29;
    localparam int VGA_PIPE_DELAY = 4;
    localparam int VGA_FRAME_W    = 16;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } vid_ctrl_t;

    // Value the delayed copies show until real timing has propagated through
    localparam vid_ctrl_t CTRL_BLANKED = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};
    localparam vid_ctrl_t CTRL_ORIGIN  = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - scan position, sync/blank and frame outputs of the timing generator
interface vga_timing_if
    import video_pkg::*;
#(
    parameter int FRAME_W = VGA_FRAME_W
);
    hcount_t              hcount_out;
    vcount_t              vcount_out;
    logic                 hsync_out;
    logic                 vsync_out;
    logic                 blank_out;
    logic                 hsync_d_out;
    logic                 vsync_d_out;
    logic                 blank_d_out;
    logic                 frame_start_out;
    logic [FRAME_W-1:0]   frame_count_out;

    modport master (
        output hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
               hsync_d_out, vsync_d_out, blank_d_out,
               frame_start_out, frame_count_out
    );

    modport slave (
        input  hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
               hsync_d_out, vsync_d_out, blank_d_out,
               frame_start_out, frame_count_out
    );
endinterface

// File: rtl/delay_line.sv
// rtl/delay_line.sv - fixed-depth shift register with synchronous reset to a preset value
module delay_line #(
    parameter int                  WIDTH     = 3,
    parameter int                  DEPTH     = 4,
    parameter logic [WIDTH-1:0]    RESET_VAL = '1
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q
);
    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = pixel_clk_in & rst_in;
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge pixel_clk_in) begin
            if (rst_in) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= RESET_VAL;
                end
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster counters with sync/blank, frame pulse and aligned delayed strobes
module vga_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int PIPE_DELAY = VGA_PIPE_DELAY,
    parameter int FRAME_W    = VGA_FRAME_W
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    vga_timing_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL >= 2**11) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL %0d does not fit in 11 bits", H_TOTAL);
    end
    if (V_TOTAL >= 2**10) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL %0d does not fit in 10 bits", V_TOTAL);
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_pipe_delay_check
        $error("vga_timing_gen: PIPE_DELAY %0d outside 0..15", PIPE_DELAY);
    end

    localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
    localparam hcount_t H_BLANK  = hcount_t'(H_ACTIVE);
    localparam hcount_t HS_FIRST = hcount_t'(H_ACTIVE + H_FP);
    localparam hcount_t HS_LAST  = hcount_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam vcount_t V_LAST   = vcount_t'(V_TOTAL - 1);
    localparam vcount_t V_BLANK  = vcount_t'(V_ACTIVE);
    localparam vcount_t VS_FIRST = vcount_t'(V_ACTIVE + V_FP);
    localparam vcount_t VS_LAST  = vcount_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    hcount_t             hcount_q, hcount_nxt;
    vcount_t             vcount_q, vcount_nxt;
    vid_ctrl_t           ctrl_q, ctrl_nxt, ctrl_d;
    logic                line_end, frame_end;
    logic                frame_start_q;
    logic [FRAME_W-1:0]  frame_count_q;

    // Strobes are decoded from the next counter values so that, once registered,
    // they describe the position shown in the same cycle.
    always_comb begin
        line_end   = (hcount_q == H_LAST);
        frame_end  = line_end && (vcount_q == V_LAST);
        hcount_nxt = line_end ? '0 : hcount_q + hcount_t'(1);
        vcount_nxt = vcount_q;
        if (line_end) begin
            vcount_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + vcount_t'(1);
        end
        ctrl_nxt.hsync = !((hcount_nxt >= HS_FIRST) && (hcount_nxt <= HS_LAST));
        ctrl_nxt.vsync = !((vcount_nxt >= VS_FIRST) && (vcount_nxt <= VS_LAST));
        ctrl_nxt.blank = (hcount_nxt >= H_BLANK) || (vcount_nxt >= V_BLANK);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            ctrl_q        <= CTRL_ORIGIN;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hcount_q      <= hcount_nxt;
            vcount_q      <= vcount_nxt;
            ctrl_q        <= ctrl_nxt;
            frame_start_q <= frame_end;
            if (frame_end) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    delay_line #(
        .WIDTH     ($bits(vid_ctrl_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (CTRL_BLANKED)
    ) u_ctrl_delay (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .d            (ctrl_q),
        .q            (ctrl_d)
    );

    assign vid.hcount_out      = hcount_q;
    assign vid.vcount_out      = vcount_q;
    assign vid.hsync_out       = ctrl_q.hsync;
    assign vid.vsync_out       = ctrl_q.vsync;
    assign vid.blank_out       = ctrl_q.blank;
    assign vid.hsync_d_out     = ctrl_d.hsync;
    assign vid.vsync_d_out     = ctrl_d.vsync;
    assign vid.blank_d_out     = ctrl_d.blank;
    assign vid.frame_start_out = frame_start_q;
    assign vid.frame_count_out = frame_count_q;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 1024x768 @ 60 Hz display path. It produces the `hcount`/`vcount` scan position that the sprite and overlay blocks consume, together with the matching sync and blank strobes. It also provides copies of sync/blank delayed by a programmable number of cycles, so they line up with pixels leaving the ROM/colour-map pipelines. It sits at the top of the video path, between the 65 MHz pixel clock and the VGA output registers.

## Interface
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (clocks)
- `H_SYNC`, 136, hsync pulse width
- `H_BP`, 160, horizontal back porch
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync pulse width
- `V_BP`, 29, vertical back porch
- `PIPE_DELAY`, 4, cycles of delay on the `_d` outputs; legal range 0..15
- `FRAME_W`, 16, frame counter width

Ports:
- `pixel_clk_in` input 1: pixel clock; all logic is on its rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `hcount_out` output 11: horizontal position, 0..H_TOTAL-1.
- `vcount_out` output 10: vertical position, 0..V_TOTAL-1.
- `hsync_out` output 1: active-low hsync, aligned with `hcount_out`.
- `vsync_out` output 1: active-low vsync, aligned with `vcount_out`.
- `blank_out` output 1: high outside the active area, aligned with the counters.
- `hsync_d_out`, `vsync_d_out`, `blank_d_out` output 1 each: the same three signals delayed by `PIPE_DELAY` cycles.
- `frame_start_out` output 1: one-cycle pulse on the first cycle of each new frame.
- `frame_count_out` output FRAME_W: number of completed frames, modulo 2^FRAME_W.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = 806.
- `hcount` increments every cycle.
  - At H_TOTAL-1 it wraps to 0, and `vcount` increments in the same cycle.
  - `vcount` wraps to 0 when it is at V_TOTAL-1 and `hcount` is at H_TOTAL-1.
- hsync is low for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 1048..1183.
- vsync is low for `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 771..776. It spans whole lines, including the hcount range.
- blank = (`hcount` ≥ H_ACTIVE) or (`vcount` ≥ V_ACTIVE).
- Sync and blank are registered. They are computed from the next-state counter values, so that on every cycle they describe the `hcount_out`/`vcount_out` being presented in that same cycle.
- frame_start:
  - Asserts in the cycle where the counters show (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1).
  - It does not assert on the first (0,0) following reset.
- `frame_count_out` increments in the same cycle as `frame_start_out` and wraps at 2^FRAME_W.
- Delay line: a shift register of depth `PIPE_DELAY` carries {hsync, vsync, blank}.
  - When `PIPE_DELAY` = 0, the `_d` outputs equal the undelayed outputs.
- Reset values, in the cycle after `rst_in` is sampled high:
  - `hcount_out` = 0, `vcount_out` = 0
  - `hsync_out` = 1, `vsync_out` = 1, `blank_out` = 0
  - `frame_start_out` = 0, `frame_count_out` = 0
  - every delay stage = {1,1,1}, so `_d` outputs read inactive sync and blanked for the first `PIPE_DELAY` cycles after reset.
- Reset mid-frame: counters return to (0,0) immediately, and the delay line is refilled with the blanked value. No frame_start is generated.
- Reset held: all outputs stay at their reset values.

## Timing
- Counter latency is zero: sync and blank are valid in the same cycle as their counters.
- `_d` latency: a `_d` output at cycle t equals the undelayed signal at cycle t−PIPE_DELAY.
- Line period: 1344 cycles. Frame period: 1344 × 806 = 1,083,264 cycles.
- There is no handshake and no stall input. The generator runs free whenever it is not in reset.
- Width rules:
  - Compare counters at full width.
  - H_TOTAL must be less than 2^11 and V_TOTAL less than 2^10. Elaboration checks both and fails with `$error` if either is violated.

## Structure
- Package `video_pkg` holds:
  - the default timing constants and the derived H_TOTAL/V_TOTAL;
  - typedef `hcount_t` = logic[10:0] and typedef `vcount_t` = logic[9:0];
  - a packed struct `vid_ctrl_t` {hsync, vsync, blank} that travels through the delay line.
- One sub-module, `delay_line`, parameterised by WIDTH, DEPTH and RESET_VAL, with synchronous reset. It is reused for pixel-path alignment elsewhere.

## Test plan
- Reset then run 1344 cycles → `hcount_out` goes 1343→0 and `vcount_out` goes 0→1 on the same edge; `blank_out` is high exactly for `hcount` 1024..1343.
- Run one full line → `hsync_out` is low exactly for `hcount` 1048..1183 (136 cycles). Run a full frame → `vsync_out` is low for `vcount` 771..776 (6 × 1344 cycles).
- Run two full frames → `frame_start_out` pulses at cycle 1,083,264 and again at 2,166,528 after reset release, with no pulse at cycle 0; `frame_count_out` reads 1 and then 2.
- With PIPE_DELAY=4 → each `_d` output equals its undelayed signal 4 cycles earlier; for the first 4 cycles after reset the `_d` outputs are {1,1,1}. Repeat with PIPE_DELAY=0 → the `_d` outputs equal the undelayed outputs.
- Assert `rst_in` for one cycle at (500,300) → next cycle shows (0,0) with `frame_count_out` = 0, `_d` outputs blanked, and no frame_start pulse.
- Run with FRAME_W=2 for 5 frames → `frame_count_out` sequence is 1,2,3,0,1.
